nts_tx_mux: RTL and testbench

Transmit-side collector for a parametrised number of NTS/NTP engines. It selects one engine with a packet ready, using a round-robin or fixed-priority arbiter, and copies that engine's TX FIFO into an internal packet buffer. It then streams the buffered packet to the MAC without gaps. It sits between the engine array and the MAC TX interface and keeps transmit and drop statistics.

---
 rtl/nts_tx_mux_if.sv | 24 ++
 rtl/nts_tx_mux.sv | 204 ++++++++++++++++++++
 tb/tb_nts_tx_mux.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nts_tx_mux_if.sv
// MAC transmit handshake between nts_tx_mux (master) and the MAC (slave).
// Frame start is requested with tx_start and accepted with tx_ack; words then stream back-to-back.
interface nts_tx_mux_if #(
  parameter int unsigned MAC_DATA_WIDTH = 64
);
  logic                      tx_start;
  logic                      tx_ack;
  logic [7:0]                tx_data_valid;
  logic [MAC_DATA_WIDTH-1:0] tx_data;

  modport master (
    output tx_start,
    output tx_data_valid,
    output tx_data,
    input  tx_ack
  );

  modport slave (
    input  tx_start,
    input  tx_data_valid,
    input  tx_data,
    output tx_ack
  );
endinterface

// File: rtl/nts_tx_mux.sv
// Collects one packet at a time from the NTS engine TX FIFOs into a local buffer,
// then streams it gap-free to the MAC, counting sent frames and buffer-overflow drops.
module nts_tx_mux #(
  parameter int unsigned ENGINES               = 4,
  parameter int unsigned MAC_DATA_WIDTH        = 64,
  parameter int unsigned LAST_DATA_VALID_WIDTH = 4,
  parameter int unsigned BUFFER_ADDR_WIDTH     = 8,
  parameter int unsigned ARB_MODE              = 0
) (
  input  logic                                       i_clk,
  input  logic                                       i_areset_n,
  input  logic [ENGINES-1:0]                         i_engine_packet_available,
  output logic [ENGINES-1:0]                         o_engine_packet_read,
  input  logic [ENGINES-1:0]                         i_engine_fifo_empty,
  output logic [ENGINES-1:0]                         o_engine_fifo_rd_start,
  input  logic [ENGINES-1:0]                         i_engine_fifo_rd_valid,
  input  logic [MAC_DATA_WIDTH*ENGINES-1:0]          i_engine_fifo_rd_data,
  input  logic [LAST_DATA_VALID_WIDTH*ENGINES-1:0]   i_engine_bytes_last_word,
  nts_tx_mux_if.master                               mac,
  output logic [31:0]                                o_tx_packet_count,
  output logic [31:0]                                o_drop_count,
  output logic                                       o_busy
);

  localparam int unsigned GW    = (ENGINES > 1) ? $clog2(ENGINES) : 1;
  localparam int unsigned DEPTH = 2 ** BUFFER_ADDR_WIDTH;
  localparam int unsigned CW    = BUFFER_ADDR_WIDTH + 1;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_FETCH    = 3'd1;
  localparam logic [2:0] ST_RELEASE  = 3'd2;
  localparam logic [2:0] ST_TX_START = 3'd3;
  localparam logic [2:0] ST_TX_DATA  = 3'd4;

  logic [2:0]                       state;
  logic [GW-1:0]                    grant_q;
  logic [GW-1:0]                    last_grant;
  logic                             fetch_first;
  logic                             seen_valid;
  logic                             overflow;
  logic [CW-1:0]                    wr_cnt;
  logic [CW-1:0]                    tx_idx;
  logic [LAST_DATA_VALID_WIDTH-1:0] blw_q;
  logic [MAC_DATA_WIDTH-1:0]        rd_q;
  logic [31:0]                      tx_cnt;
  logic [31:0]                      drop_cnt;

  logic [MAC_DATA_WIDTH-1:0]        mem [DEPTH];

  logic [MAC_DATA_WIDTH-1:0]        eng_word [ENGINES];
  logic [LAST_DATA_VALID_WIDTH-1:0] eng_blw  [ENGINES];

  logic                             arb_found;
  logic [GW-1:0]                    arb_idx;
  logic                             valid_g;
  logic                             wr_en;
  logic                             is_last;
  logic                             tx_active;
  logic [3:0]                       nbytes;
  logic [7:0]                       last_mask;
  logic                             unused_fifo_empty;

  // The FIFO-empty flags are redundant with the rd_valid framing used to delimit a packet.
  assign unused_fifo_empty = ^i_engine_fifo_empty;

  for (genvar i = 0; i < ENGINES; i++) begin : g_slice
    assign eng_word[i] = i_engine_fifo_rd_data[i*MAC_DATA_WIDTH +: MAC_DATA_WIDTH];
    assign eng_blw[i]  = i_engine_bytes_last_word[i*LAST_DATA_VALID_WIDTH +: LAST_DATA_VALID_WIDTH];
  end

  // Round-robin scans from the engine after the last grant; fixed priority scans from 0.
  always_comb begin
    logic [GW-1:0] cand;
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < ENGINES; i++) begin
      if (ARB_MODE == 1)
        cand = GW'(i);
      else
        cand = GW'((32'(last_grant) + 32'd1 + i) % ENGINES);
      if (!arb_found && i_engine_packet_available[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  assign valid_g   = i_engine_fifo_rd_valid[grant_q];
  assign wr_en     = (state == ST_FETCH) && valid_g && !wr_cnt[BUFFER_ADDR_WIDTH];
  assign is_last   = (tx_idx == wr_cnt - CW'(1));
  assign tx_active = (state == ST_TX_START) || (state == ST_TX_DATA);

  // Last-word lane mask: n valid bytes occupy the n most significant lanes; 0 encodes 8.
  always_comb begin
    nbytes = 4'd8;
    if (blw_q != '0 && 32'(blw_q) < 32'd8)
      nbytes = 4'(blw_q);
    last_mask = ~(8'hFF >> nbytes);
  end

  always_comb begin
    o_engine_fifo_rd_start = '0;
    o_engine_packet_read   = '0;
    if (state == ST_FETCH && fetch_first)
      o_engine_fifo_rd_start[grant_q] = 1'b1;
    if (state == ST_RELEASE)
      o_engine_packet_read[grant_q] = 1'b1;
  end

  assign mac.tx_start      = (state == ST_TX_START);
  assign mac.tx_data       = tx_active ? rd_q : '0;
  assign mac.tx_data_valid = !tx_active ? 8'h00 : (is_last ? last_mask : 8'hFF);

  assign o_tx_packet_count = tx_cnt;
  assign o_drop_count      = drop_cnt;
  assign o_busy            = (state != ST_IDLE);

  always_ff @(posedge i_clk) begin
    if (wr_en)
      mem[BUFFER_ADDR_WIDTH'(wr_cnt)] <= eng_word[grant_q];
  end

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state       <= ST_IDLE;
      grant_q     <= '0;
      last_grant  <= GW'(ENGINES - 1);
      fetch_first <= 1'b0;
      seen_valid  <= 1'b0;
      overflow    <= 1'b0;
      wr_cnt      <= '0;
      tx_idx      <= '0;
      blw_q       <= '0;
      rd_q        <= '0;
      tx_cnt      <= '0;
      drop_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_found) begin
            grant_q     <= arb_idx;
            last_grant  <= arb_idx;
            fetch_first <= 1'b1;
            seen_valid  <= 1'b0;
            overflow    <= 1'b0;
            wr_cnt      <= '0;
            state       <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          fetch_first <= 1'b0;
          if (valid_g) begin
            seen_valid <= 1'b1;
            // A full buffer is a legal count; only a word arriving while full overflows.
            if (wr_cnt[BUFFER_ADDR_WIDTH])
              overflow <= 1'b1;
            else
              wr_cnt <= wr_cnt + CW'(1);
          end else if (seen_valid) begin
            blw_q <= eng_blw[grant_q];
            state <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          rd_q   <= mem[0];
          tx_idx <= '0;
          if (overflow) begin
            if (drop_cnt != '1)
              drop_cnt <= drop_cnt + 32'd1;
            state <= ST_IDLE;
          end else begin
            state <= ST_TX_START;
          end
        end
        ST_TX_START: begin
          if (mac.tx_ack) begin
            if (is_last) begin
              if (tx_cnt != '1)
                tx_cnt <= tx_cnt + 32'd1;
              state <= ST_IDLE;
            end else begin
              rd_q   <= mem[BUFFER_ADDR_WIDTH'(tx_idx + CW'(1))];
              tx_idx <= tx_idx + CW'(1);
              state  <= ST_TX_DATA;
            end
          end
        end
        ST_TX_DATA: begin
          if (is_last) begin
            if (tx_cnt != '1)
              tx_cnt <= tx_cnt + 32'd1;
            state <= ST_IDLE;
          end else begin
            rd_q   <= mem[BUFFER_ADDR_WIDTH'(tx_idx + CW'(1))];
            tx_idx <= tx_idx + CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nts_tx_mux.sv
// Directed bench for nts_tx_mux: two instances (round-robin and fixed priority, 16-word buffers)
// driven by a small engine/MAC model; expectations are hand-computed per scenario.
`timescale 1ns/1ps
module tb_nts_tx_mux;
  localparam int unsigned NE = 4;

  logic clk;
  logic rst_n;

  logic [NE-1:0]    avail   [2];
  logic [NE-1:0]    pread   [2];
  logic [NE-1:0]    fempty  [2];
  logic [NE-1:0]    rdstart [2];
  logic [NE-1:0]    rdvalid [2];
  logic [64*NE-1:0] rddata  [2];
  logic [4*NE-1:0]  blw     [2];
  logic             ack     [2];
  logic             start   [2];
  logic [7:0]       valid   [2];
  logic [63:0]      txd     [2];
  logic [31:0]      txc     [2];
  logic [31:0]      dropc   [2];
  logic             busy    [2];

  for (genvar d = 0; d < 2; d++) begin : g_dut
    nts_tx_mux_if #(.MAC_DATA_WIDTH(64)) mif ();
    assign mif.tx_ack = ack[d];
    assign start[d]   = mif.tx_start;
    assign valid[d]   = mif.tx_data_valid;
    assign txd[d]     = mif.tx_data;

    nts_tx_mux #(
      .ENGINES(NE), .MAC_DATA_WIDTH(64), .LAST_DATA_VALID_WIDTH(4),
      .BUFFER_ADDR_WIDTH(4), .ARB_MODE(d)
    ) u_dut (
      .i_clk                     (clk),
      .i_areset_n                (rst_n),
      .i_engine_packet_available (avail[d]),
      .o_engine_packet_read      (pread[d]),
      .i_engine_fifo_empty       (fempty[d]),
      .o_engine_fifo_rd_start    (rdstart[d]),
      .i_engine_fifo_rd_valid    (rdvalid[d]),
      .i_engine_fifo_rd_data     (rddata[d]),
      .i_engine_bytes_last_word  (blw[d]),
      .mac                       (mif),
      .o_tx_packet_count         (txc[d]),
      .o_drop_count              (dropc[d]),
      .o_busy                    (busy[d])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int queued [2][NE];
  int plen   [2][NE];
  int left   [2][NE];
  int widx   [2][NE];
  int pid    [2][NE];
  int pkts   [2][NE];
  int prd    [2][NE];
  int dlv    [2][NE];
  logic [3:0] bl [2][NE];
  int ack_dly [2];
  int wcnt    [2];
  int stcnt   [2];
  bit ackf    [2];
  int avrise  [2];
  int gcyc    [2];
  int lastv   [2];
  int prcyc   [2];
  logic [71:0] cap0  [$];
  int          capc0 [$];
  int          g0    [$];
  int          g1    [$];

  int n_cmp = 0;
  int n_mis = 0;

  function automatic logic [63:0] mkword(input int e, input int p, input int j);
    return {8'(e), 24'(p), 32'(j)};
  endfunction

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      for (int e = 0; e < NE; e++) begin
        queued[d][e] = 0; plen[d][e] = 0; left[d][e] = 0; widx[d][e] = 0;
        pid[d][e] = 0; pkts[d][e] = 0; prd[d][e] = 0; dlv[d][e] = 0; bl[d][e] = 4'd0;
      end
      ack_dly[d] = 0; wcnt[d] = 0; stcnt[d] = 0; ackf[d] = 1'b0;
      avrise[d] = 0; gcyc[d] = 0; lastv[d] = 0; prcyc[d] = 0;
    end
    cap0.delete(); capc0.delete(); g0.delete(); g1.delete();
  endtask

  task automatic wait_txc(input int d, input int tgt, input string tag);
    int n = 0;
    while (txc[d] != 32'(tgt) && n < 500) begin
      tick(1);
      n++;
    end
    check(tag, 72'(txc[d]), 72'(tgt));
  endtask

  // Engine FIFO and MAC responder: reacts on the falling edge, away from the DUT's sampling edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        logic [NE-1:0] prev_av;
        prev_av = avail[d];
        for (int e = 0; e < NE; e++) begin
          if (left[d][e] > 0) begin
            rdvalid[d][e] = 1'b1;
            rddata[d][64*e +: 64] = mkword(e, pid[d][e], widx[d][e]);
            widx[d][e]++; left[d][e]--; dlv[d][e]++;
            lastv[d] = cyc;
          end else begin
            rdvalid[d][e] = 1'b0;
          end
          if (rdstart[d][e]) begin
            left[d][e] = plen[d][e]; widx[d][e] = 0;
            pid[d][e] = pkts[d][e]; pkts[d][e]++;
            gcyc[d] = cyc;
            if (d == 0) g0.push_back(e); else g1.push_back(e);
          end
          if (pread[d][e]) begin
            if (queued[d][e] > 0) queued[d][e]--;
            prd[d][e]++;
            prcyc[d] = cyc;
          end
          avail[d][e]  = (queued[d][e] > 0);
          fempty[d][e] = (left[d][e] == 0);
          blw[d][4*e +: 4] = bl[d][e];
        end
        if (prev_av == '0 && avail[d] != '0) avrise[d] = cyc;
        if (start[d]) begin
          stcnt[d]++;
          if (wcnt[d] >= ack_dly[d]) begin
            ack[d] = 1'b1; ackf[d] = 1'b1;
          end else begin
            ack[d] = 1'b0; wcnt[d]++;
          end
        end else begin
          ack[d] = 1'b0; wcnt[d] = 0;
        end
        if (d == 0 && valid[0] != 8'h00 && (!start[0] || ack[0])) begin
          cap0.push_back({valid[0], txd[0]});
          capc0.push_back(cyc);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      avail[d] = '0; rdvalid[d] = '0; rddata[d] = '0; blw[d] = '0; fempty[d] = '1; ack[d] = 1'b0;
    end
    model_clear();
    tick(3);

    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst%0d_start", d), 72'(start[d]), 72'(0));
      check($sformatf("rst%0d_valid", d), 72'(valid[d]), 72'(0));
      check($sformatf("rst%0d_data", d), 72'(txd[d]), 72'(0));
      check($sformatf("rst%0d_txc", d), 72'(txc[d]), 72'(0));
      check($sformatf("rst%0d_drop", d), 72'(dropc[d]), 72'(0));
      check($sformatf("rst%0d_busy", d), 72'(busy[d]), 72'(0));
      check($sformatf("rst%0d_rdstart", d), 72'(rdstart[d]), 72'(0));
      check($sformatf("rst%0d_pread", d), 72'(pread[d]), 72'(0));
    end
    rst_n = 1'b1;
    tick(2);

    // Single 3-word packet from engine 0, 5 bytes in the last word, ack after 4 waiting cycles.
    model_clear();
    plen[0][0] = 3; bl[0][0] = 4'd5; ack_dly[0] = 4; queued[0][0] = 1;
    wait_txc(0, 1, "t1_txcount");
    tick(2);
    check("t1_nwords", 72'(cap0.size()), 72'(3));
    check("t1_w0", cap0[0], {8'hFF, mkword(0, 0, 0)});
    check("t1_w1", cap0[1], {8'hFF, mkword(0, 0, 1)});
    check("t1_w2", cap0[2], {8'hF8, mkword(0, 0, 2)});
    check("t1_nogap", 72'(capc0[2] - capc0[0]), 72'(2));
    check("t1_start_cycles", 72'(stcnt[0]), 72'(5));
    check("t1_pread", 72'(prd[0][0]), 72'(1));
    check("t1_grant_latency", 72'(gcyc[0] - avrise[0]), 72'(1));
    check("t1_idle", 72'(busy[0]), 72'(0));
    check("t1_valid_after", 72'(valid[0]), 72'(0));

    // Round-robin between permanently available engines 1 and 2.
    model_clear();
    plen[0][1] = 2; plen[0][2] = 2; queued[0][1] = 3; queued[0][2] = 3;
    wait_txc(0, 7, "t2_txcount");
    check("t2_ngrants", 72'(g0.size()), 72'(6));
    for (int i = 0; i < 6; i++)
      check($sformatf("t2_grant%0d", i), 72'(g0[i]), 72'((i % 2 == 0) ? 1 : 2));

    // Fixed priority: engine 0 wins until its queue empties.
    model_clear();
    plen[1][0] = 1; plen[1][3] = 1; queued[1][0] = 3; queued[1][3] = 2;
    wait_txc(1, 5, "t3_txcount");
    check("t3_ngrants", 72'(g1.size()), 72'(5));
    for (int i = 0; i < 5; i++)
      check($sformatf("t3_grant%0d", i), 72'(g1[i]), 72'((i < 3) ? 0 : 3));

    // Overflow: 20 words into a 16-word buffer are drained and dropped.
    model_clear();
    plen[0][1] = 20; bl[0][1] = 4'd3; queued[0][1] = 1;
    begin
      int n = 0;
      while (dropc[0] != 32'd1 && n < 500) begin
        tick(1);
        n++;
      end
    end
    check("t4_drop", 72'(dropc[0]), 72'(1));
    tick(3);
    check("t4_drained", 72'(dlv[0][1]), 72'(20));
    check("t4_release_after_drain", 72'(prcyc[0] - lastv[0]), 72'(2));
    check("t4_pread", 72'(prd[0][1]), 72'(1));
    check("t4_nostart", 72'(stcnt[0]), 72'(0));
    check("t4_txc_held", 72'(txc[0]), 72'(7));
    check("t4_idle", 72'(busy[0]), 72'(0));

    model_clear();
    plen[0][1] = 16; bl[0][1] = 4'd0; ack_dly[0] = 2; queued[0][1] = 1;
    wait_txc(0, 8, "t4_full_txcount");
    tick(2);
    check("t4_full_nwords", 72'(cap0.size()), 72'(16));
    for (int j = 0; j < 16; j++)
      check($sformatf("t4_full_w%0d", j), cap0[j], {8'hFF, mkword(1, 0, j)});
    check("t4_full_nogap", 72'(capc0[15] - capc0[0]), 72'(15));
    check("t4_full_drop", 72'(dropc[0]), 72'(1));

    // Single-word packet, bytes_last 0 meaning a full word.
    model_clear();
    plen[0][2] = 1; bl[0][2] = 4'd0; ack_dly[0] = 1; queued[0][2] = 1;
    begin
      int n = 0;
      while (!ackf[0] && n < 200) begin
        tick(1);
        n++;
      end
    end
    check("t5_ack_seen", 72'(ackf[0]), 72'(1));
    check("t5_idle_after_ack", 72'(busy[0]), 72'(0));
    check("t5_valid_after_ack", 72'(valid[0]), 72'(0));
    tick(2);
    check("t5_nwords", 72'(cap0.size()), 72'(1));
    check("t5_w0", cap0[0], {8'hFF, mkword(2, 0, 0)});
    check("t5_txcount", 72'(txc[0]), 72'(9));

    // Asynchronous reset while the second of four words is on the bus.
    model_clear();
    plen[0][0] = 4; queued[0][0] = 1;
    begin
      int n = 0;
      while (cap0.size() < 1 && n < 200) begin
        tick(1);
        n++;
      end
    end
    check("t6_word1_on_bus", 72'(txd[0]), 72'(mkword(0, 0, 1)));
    rst_n = 1'b0;
    #1;
    check("t6_start", 72'(start[0]), 72'(0));
    check("t6_valid", 72'(valid[0]), 72'(0));
    check("t6_data", 72'(txd[0]), 72'(0));
    check("t6_busy", 72'(busy[0]), 72'(0));
    check("t6_txc", 72'(txc[0]), 72'(0));
    check("t6_drop", 72'(dropc[0]), 72'(0));
    model_clear();
    tick(2);
    rst_n = 1'b1;
    tick(1);
    plen[0][0] = 1; plen[0][1] = 1; queued[0][0] = 1; queued[0][1] = 1;
    wait_txc(0, 2, "t6_txcount");
    check("t6_ngrants", 72'(g0.size()), 72'(2));
    check("t6_first_grant", 72'(g0[0]), 72'(0));
    check("t6_second_grant", 72'(g0[1]), 72'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
